// File: rtl/wide_add_sequencer.sv
// Multi-cycle wide adder: adds two WORDS x 64-bit operands one 64-bit word per
// cycle, least-significant word first, with the carry chained through a register.
module wide_add_sequencer #(
    parameter int unsigned WORDS = 4,
    parameter int unsigned CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [64*WORDS-1:0]   a,
    input  logic [64*WORDS-1:0]   b,
    input  logic                  c_in,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [64*WORDS-1:0]   sum,
    output logic                  c_out,
    output logic                  busy,
    output logic [CNT_W-1:0]      op_count
);

    localparam int unsigned W     = 64 * WORDS;
    localparam int unsigned IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [64:0]      word_sum;

    // The single shared 64-bit add stage, steered by the word index.
    always_comb begin
        word_sum = {1'b0, a_reg[64*idx +: 64]} + {1'b0, b_reg[64*idx +: 64]} + 65'(carry);
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= c_in;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        sum[64*idx +: 64] <= word_sum[63:0];
                        carry             <= word_sum[64];
                        idx               <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            c_out     <= word_sum[64];
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    // abort wins over a simultaneous consume, so the count is left alone
                    if (abort) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (op_count != '1) begin
                            op_count <= op_count + 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
